cnt_mod_n: RTL and testbench



---
 rtl/cnt_mod_n.sv | 137 +++++++++++++
 tb/tb_cnt_mod_n.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cnt_mod_n.sv
// Purpose : modulo-MODULUS counter built from DIGITS cascaded 4-bit stages (hex or BCD coded),
//           with enable, up/down, range-checked parallel load, carry and wrap/error pulses.
// Latency : Q, WRAP, ERR update one Clk edge after the inputs; C is combinational (zero latency).
// Backpr. : none; EN qualifies counting, and C feeds the EN of a following instance.
// Ports   : Clk, MR (async active-high reset), EN, UP, LD, D[4*DIGITS-1:0]  -> inputs
//           Q[4*DIGITS-1:0] count, C terminal/carry, WRAP wrap pulse, ERR bad-load pulse -> outputs
module cnt_mod_n #(
   parameter int DIGITS  = 2,
   parameter int MODULUS = 121,
   parameter bit BCD     = 1'b0
) (
   input  logic                  Clk,
   input  logic                  MR,
   input  logic                  EN,
   input  logic                  UP,
   input  logic                  LD,
   input  logic [4*DIGITS-1:0]   D,
   output logic [4*DIGITS-1:0]   Q,
   output logic                  C,
   output logic                  WRAP,
   output logic                  ERR
);

   localparam int         W    = 4 * DIGITS;
   localparam logic [3:0] DMAX = BCD ? 4'd9 : 4'd15;

   function automatic longint pow_l(input int b, input int n);
      longint r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * b;
      return r;
   endfunction

   // Encode an integer into the digit coding used on Q/D.
   function automatic logic [W-1:0] enc(input int v);
      logic [W-1:0] r;
      int           rem;
      int           base;
      r    = '0;
      rem  = v;
      base = BCD ? 10 : 16;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(rem % base);
         rem         = rem / base;
      end
      return r;
   endfunction

   localparam logic [W-1:0] TERM = enc(MODULUS - 1);

   generate
      if (MODULUS < 2) begin : g_chk_min
         $error("cnt_mod_n: MODULUS must be at least 2");
      end
      if (longint'(MODULUS) > pow_l(BCD ? 10 : 16, DIGITS)) begin : g_chk_max
         $error("cnt_mod_n: MODULUS does not fit in DIGITS digit stages");
      end
   endgenerate

   logic [W-1:0]      q_q, q_d;
   logic              wrap_q, wrap_d;
   logic              err_q, err_d;
   logic [W-1:0]      inc_val, dec_val;
   logic [DIGITS-1:0] cy, bw, dig_ok;
   logic              at_top, at_zero, d_valid;

   assign cy[0] = 1'b1;
   assign bw[0] = 1'b1;

   // Per-digit step logic: a digit moves only when every lower digit is at its
   // rollover value (DMAX going up, 0 going down).
   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      logic [3:0] dig;
      assign dig = q_q[4*i +: 4];
      assign inc_val[4*i +: 4] = cy[i] ? ((dig == DMAX) ? 4'd0 : dig + 4'd1) : dig;
      assign dec_val[4*i +: 4] = bw[i] ? ((dig == 4'd0) ? DMAX : dig - 4'd1) : dig;
      assign dig_ok[i]         = !BCD || (D[4*i +: 4] <= 4'd9);
      if (i < DIGITS - 1) begin : g_chain
         assign cy[i+1] = cy[i] & (dig == DMAX);
         assign bw[i+1] = bw[i] & (dig == 4'd0);
      end
   end

   assign at_top  = (q_q == TERM);
   assign at_zero = (q_q == '0);
   // With every digit legal, packed-vector order matches numeric order in both
   // codings, so a plain compare against the top value is a range check.
   assign d_valid = (&dig_ok) && (D <= TERM);

   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      err_d  = 1'b0;
      if (LD) begin
         if (d_valid) begin
            q_d = D;
         end else begin
            q_d   = '0;
            err_d = 1'b1;
         end
      end else if (EN) begin
         if (UP) begin
            if (at_top) begin
               q_d    = '0;
               wrap_d = 1'b1;
            end else begin
               q_d = inc_val;
            end
         end else begin
            if (at_zero) begin
               q_d    = TERM;
               wrap_d = 1'b1;
            end else begin
               q_d = dec_val;
            end
         end
      end
   end

   always_ff @(posedge Clk or posedge MR) begin
      if (MR) begin
         q_q    <= '0;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
         err_q  <= err_d;
      end
   end

   assign Q    = q_q;
   assign WRAP = wrap_q;
   assign ERR  = err_q;
   assign C    = EN & (UP ? at_top : at_zero);

endmodule

// File: tb/tb_cnt_mod_n.sv
module tb_cnt_mod_n;

   logic        Clk, MR;
   // default hex instance: DIGITS=2, MODULUS=121
   logic        h_en, h_up, h_ld, h_c, h_wrap, h_err;
   logic [7:0]  h_d, h_q;
   // BCD instance: DIGITS=3, MODULUS=121
   logic        b_en, b_up, b_ld, b_c, b_wrap, b_err;
   logic [11:0] b_d, b_q;
   // cascade of two BCD decades
   logic        c_en, c_ld;
   logic [3:0]  c_d, c_q0, c_q1;
   logic        c_c0, c_c1, c_w0, c_w1, c_e0, c_e1;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_v;
   logic exp_w;

   cnt_mod_n u_hex (.Clk(Clk), .MR(MR), .EN(h_en), .UP(h_up), .LD(h_ld), .D(h_d),
                    .Q(h_q), .C(h_c), .WRAP(h_wrap), .ERR(h_err));

   cnt_mod_n #(.DIGITS(3), .MODULUS(121), .BCD(1'b1)) u_bcd (
      .Clk(Clk), .MR(MR), .EN(b_en), .UP(b_up), .LD(b_ld), .D(b_d),
      .Q(b_q), .C(b_c), .WRAP(b_wrap), .ERR(b_err));

   cnt_mod_n #(.DIGITS(1), .MODULUS(10), .BCD(1'b1)) u_cas0 (
      .Clk(Clk), .MR(MR), .EN(c_en), .UP(1'b1), .LD(c_ld), .D(c_d),
      .Q(c_q0), .C(c_c0), .WRAP(c_w0), .ERR(c_e0));

   cnt_mod_n #(.DIGITS(1), .MODULUS(10), .BCD(1'b1)) u_cas1 (
      .Clk(Clk), .MR(MR), .EN(c_c0), .UP(1'b1), .LD(c_ld), .D(c_d),
      .Q(c_q1), .C(c_c1), .WRAP(c_w1), .ERR(c_e1));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r;
      int          t;
      r = '0;
      t = v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   initial begin
      MR = 1'b0;
      h_en = 0; h_up = 1; h_ld = 0; h_d = '0;
      b_en = 0; b_up = 1; b_ld = 0; b_d = '0;
      c_en = 0; c_ld = 0; c_d = '0;
      #1 MR = 1'b1;
      #1;
      chk("rst_hex_q", 32'(h_q), 0);
      chk("rst_hex_wrap", 32'(h_wrap), 0);
      chk("rst_hex_err", 32'(h_err), 0);
      chk("rst_bcd_q", 32'(b_q), 0);
      chk("rst_cas_q", {24'd0, c_q1, c_q0}, 0);
      chk("rst_cas_flags", {28'd0, c_w0, c_w1, c_e0, c_e1}, 0);
      #6 MR = 1'b0;

      // Hex up-count through a full wrap.
      h_en = 1; h_up = 1;
      exp_v = 0;
      for (int i = 0; i < 125; i++) begin
         #1;
         chk("hex_up_c", 32'(h_c), 32'(exp_v == 120));
         exp_w = (exp_v == 120);
         exp_v = (exp_v == 120) ? 0 : exp_v + 1;
         step();
         chk("hex_up_q", 32'(h_q), 32'(exp_v));
         chk("hex_up_wrap", 32'(h_wrap), 32'(exp_w));
      end

      // Direction changes across a digit boundary.
      h_en = 0; h_ld = 1; h_d = 8'h10; step();
      chk("dir_load", 32'(h_q), 32'h10);
      h_ld = 0; h_en = 1; h_up = 1; step();
      chk("dir_up", 32'(h_q), 32'h11);
      h_up = 0; step();
      chk("dir_dn1", 32'(h_q), 32'h10);
      step();
      chk("dir_dn_borrow", 32'(h_q), 32'h0F);
      h_up = 1; step();
      chk("dir_up_carry", 32'(h_q), 32'h10);

      // Hex loads: invalid, valid top, load beats count at terminal, down-wrap.
      h_en = 0; h_ld = 1; h_d = 8'h79; step();
      chk("hex_bad_q", 32'(h_q), 0);
      chk("hex_bad_err", 32'(h_err), 1);
      h_ld = 0; step();
      chk("hex_err_clr", 32'(h_err), 0);
      h_ld = 1; h_d = 8'h78; step();
      chk("hex_ld_top", 32'(h_q), 32'h78);
      chk("hex_ld_top_err", 32'(h_err), 0);
      h_d = 8'h05; h_en = 1; h_up = 1; #1;
      chk("hex_ld_en_c", 32'(h_c), 1);
      step();
      chk("hex_ld_wins_q", 32'(h_q), 32'h05);
      chk("hex_ld_wins_wrap", 32'(h_wrap), 0);
      h_en = 0; h_d = 8'h00; step();
      h_ld = 0; h_en = 1; h_up = 0; #1;
      chk("hex_dn_c", 32'(h_c), 1);
      step();
      chk("hex_dn_wrap_q", 32'(h_q), 32'h78);
      chk("hex_dn_wrap", 32'(h_wrap), 1);
      h_en = 0; step();
      chk("hex_wrap_clr", 32'(h_wrap), 0);

      // BCD up-count through a full wrap; equality also rules out A-F digits.
      b_en = 1; b_up = 1;
      exp_v = 0;
      for (int i = 0; i < 125; i++) begin
         #1;
         chk("bcd_up_c", 32'(b_c), 32'(exp_v == 120));
         exp_w = (exp_v == 120);
         exp_v = (exp_v == 120) ? 0 : exp_v + 1;
         step();
         chk("bcd_up_q", 32'(b_q), to_bcd(exp_v));
         chk("bcd_up_wrap", 32'(b_wrap), 32'(exp_w));
      end

      // BCD loads.
      b_en = 0; b_ld = 1; b_d = 12'h0A5; step();
      chk("bcd_bad_dig_q", 32'(b_q), 0);
      chk("bcd_bad_dig_err", 32'(b_err), 1);
      b_d = 12'h121; step();
      chk("bcd_bad_rng_q", 32'(b_q), 0);
      chk("bcd_bad_rng_err", 32'(b_err), 1);
      b_d = 12'h120; step();
      chk("bcd_ld_top", 32'(b_q), 32'h120);
      chk("bcd_ld_top_err", 32'(b_err), 0);

      // BCD down-count with decimal borrow and down-wrap.
      b_d = 12'h100; step();
      chk("bcd_ld100", 32'(b_q), 32'h100);
      b_ld = 0; b_en = 1; b_up = 0; step();
      chk("bcd_dn099", 32'(b_q), 32'h099);
      step();
      chk("bcd_dn098", 32'(b_q), 32'h098);
      b_en = 0; b_ld = 1; b_d = 12'h000; step();
      chk("bcd_ld0", 32'(b_q), 0);
      b_ld = 0; b_en = 1; b_up = 0; #1;
      chk("bcd_dn_c", 32'(b_c), 1);
      step();
      chk("bcd_dn_wrap_q", 32'(b_q), 32'h120);
      chk("bcd_dn_wrap", 32'(b_wrap), 1);
      b_en = 0; step();
      chk("bcd_hold_q", 32'(b_q), 32'h120);
      chk("bcd_wrap_clr", 32'(b_wrap), 0);

      // Asynchronous reset between edges, held, then released.
      h_en = 0; h_ld = 1; h_d = 8'h45; step();
      h_ld = 0;
      chk("ar_pre", 32'(h_q), 32'h45);
      #3 MR = 1'b1;
      #1;
      chk("ar_async_q", 32'(h_q), 0);
      chk("ar_async_bcd", 32'(b_q), 0);
      h_en = 1; h_up = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("ar_held_q", 32'(h_q), 0);
      end
      MR = 1'b0;
      step();
      chk("ar_release_q", 32'(h_q), 32'h01);

      // Reset during a wrap edge and during a bad-load edge: no pulse after.
      h_en = 0; h_ld = 1; h_d = 8'h78; step();
      h_ld = 0; h_en = 1; h_up = 1;
      #2 MR = 1'b1;
      step();
      chk("ar_wrap_q", 32'(h_q), 0);
      chk("ar_wrap_pulse", 32'(h_wrap), 0);
      h_en = 0; h_ld = 1; h_d = 8'h79;
      step();
      chk("ar_ld_err", 32'(h_err), 0);
      h_ld = 0; MR = 1'b0;
      step();
      chk("ar_after_wrap", 32'(h_wrap), 0);
      chk("ar_after_err", 32'(h_err), 0);

      // Two cascaded decades count 00..99 without gaps.
      c_en = 1;
      exp_v = 0;
      for (int i = 0; i < 102; i++) begin
         #1;
         chk("cas_c1", 32'(c_c1), 32'(exp_v == 99));
         exp_v = (exp_v == 99) ? 0 : exp_v + 1;
         step();
         chk("cas_q", {24'd0, c_q1, c_q0}, to_bcd(exp_v));
      end
      c_en = 0; #1;
      chk("cas_c1_idle", 32'(c_c1), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
